sobel_grad_pipe: RTL and testbench
==================================

SOBEL_GRAD_PIPE -- requirements
Module: sobel_grad_pipe

Interface
REQ-001 Parameter PIX_W, default 4, unsigned pixel width in bits (legal range 2..12).
REQ-002 Parameter CNT_W, default 16, width of the edge counter.
REQ-003 Clk  input  1  rising-edge clock for all state.
REQ-004 Rst  input  1  reset; the clock is single, and Rst is asynchronous and active-high.
REQ-005 in_valid  input  1  window beat present.
REQ-006 in_ready  output  1  beat accepted when in_valid && in_ready.
REQ-007 p1..p9  input  PIX_W each  unsigned 3x3 window, row-major (p1 top-left, p9 bottom-right).
REQ-008 mode  input  2  00=Gx, 01=Gy, 10=|Gx|+|Gy|, 11=reserved (treated as 10); sampled with the beat.
REQ-009 thresh  input  PIX_W+3  unsigned edge threshold; sampled with the beat.
REQ-010 cnt_clr  input  1  synchronous clear of edge_count.
REQ-011 out_valid  output  1  result present.
REQ-012 out_ready  input  1  downstream accepts the result when out_valid && out_ready.
REQ-013 grad  output  PIX_W+4  result: two's complement in Gx/Gy modes, zero-extended magnitude otherwise.
REQ-014 edge  output  1  |Gx|+|Gy| > thresh for this beat, in every mode.
REQ-015 edge_count  output  CNT_W  count of delivered beats with edge=1.

Function
REQ-016 Gx SHALL equal p1 - p3 + 2*p4 - 2*p6 + p7 - p9, computed exactly in PIX_W+4 signed bits.
REQ-017 Gy SHALL equal p1 + 2*p2 + p3 - p7 - 2*p8 - p9, computed exactly in PIX_W+4 signed bits.
REQ-018 Stage 1 SHALL register the six signed weighted terms for each kernel, with negation by two's complement and x2 by left shift.
REQ-019 Stage 2 SHALL register Gx and Gy, and the mode and thresh values carried with the beat.
REQ-020 Stage 3 SHALL register grad, edge and out_valid, and the magnitude SHALL be computed as |Gx|+|Gy| (maximum 8*(2^PIX_W-1), no overflow).
REQ-021 Latency SHALL be exactly 3 cycles from the accepting edge to out_valid=1 when there is no stall.
REQ-022 Each stage SHALL carry a valid bit; a bubble (in_valid=0) SHALL propagate as valid=0.
REQ-023 The pipeline SHALL advance when !(out_valid && !out_ready), and in_ready SHALL equal that advance term combinationally.
REQ-024 While stalled, all stage registers SHALL hold, grad/edge SHALL remain stable, and out_valid SHALL remain 1.
REQ-025 Throughput SHALL be one beat per cycle when out_ready=1 continuously.
REQ-026 edge_count SHALL increment on each output handshake with edge=1, and SHALL saturate at 2^CNT_W-1.
REQ-027 If cnt_clr and an incrementing handshake occur in the same cycle, edge_count SHALL become 0 (clear wins).
REQ-028 mode and thresh changes SHALL affect only beats accepted after the change, never beats already in flight.

Reset
REQ-029 Asserting Rst SHALL immediately clear all stage valid bits, out_valid, grad, edge and edge_count to 0.
REQ-030 Asserting Rst mid-stream SHALL discard in-flight beats, and no result from them SHALL appear after reset.
REQ-031 in_ready SHALL be 1 during and after reset, because out_valid=0.
REQ-032 The first beat accepted after Rst deasserts SHALL appear 3 cycles later.

Verification (PIX_W=4, CNT_W=16)
REQ-033 All pixels 5, mode=00, thresh=0 -> grad=0x00 and edge=0 at cycle +3.
REQ-034 Left column 15 and the rest 0, mode=00 -> grad=60 (0x3C); mode=10 -> 60; thresh=50 -> edge=1, and edge_count increments by 1.
REQ-035 Right column 15 and the rest 0, mode=00 -> grad=-60 (0xC4); top row 15, mode=01 -> grad=60; bottom row 15, mode=01 -> 0xC4.
REQ-036 p1=p2=p4=15 and the rest 0, mode=10 -> Gx=45, Gy=45, grad=90 (0x5A) and edge=1 with thresh=89, or edge=0 with thresh=90.
REQ-037 Back-to-back beats A,B,C,D with out_ready low for 4 cycles after A reaches the output -> A held stable, in_ready=0 during the stall, then A,B,C,D delivered in order with none lost or duplicated.
REQ-038 Rst pulsed with 3 beats in flight -> out_valid=0 immediately and no stale result appears afterwards; edge_count at 0xFFFF plus one edge handshake -> stays 0xFFFF; cnt_clr concurrent with an edge handshake -> 0.

Source files
------------

// File: rtl/sobel_grad_pipe.sv
// Three-stage Sobel gradient pipeline on a 3x3 pixel window.
// Stage 1 registers the weighted kernel terms, stage 2 the Gx/Gy sums, and
// stage 3 the selected result and the edge flag. One global advance term
// stalls every stage together when a result is waiting on downstream.
module sobel_grad_pipe #(
    parameter int unsigned PIX_W = 4,
    parameter int unsigned CNT_W = 16
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    input  logic                 i_in_valid,
    output logic                 o_in_ready,
    input  logic [PIX_W-1:0]     i_p1,
    input  logic [PIX_W-1:0]     i_p2,
    input  logic [PIX_W-1:0]     i_p3,
    input  logic [PIX_W-1:0]     i_p4,
    input  logic [PIX_W-1:0]     i_p5,
    input  logic [PIX_W-1:0]     i_p6,
    input  logic [PIX_W-1:0]     i_p7,
    input  logic [PIX_W-1:0]     i_p8,
    input  logic [PIX_W-1:0]     i_p9,
    input  logic [1:0]           i_mode,
    input  logic [PIX_W+2:0]     i_thresh,
    input  logic                 i_cnt_clr,
    output logic                 o_out_valid,
    input  logic                 i_out_ready,
    output logic [PIX_W+3:0]     o_grad,
    output logic                 o_edge,
    output logic [CNT_W-1:0]     o_edge_count
);

    localparam int unsigned GW = PIX_W + 4;
    localparam int unsigned TW = PIX_W + 3;

    typedef logic signed [GW-1:0] term_t;

    typedef enum logic [1:0] {
        ModeGx  = 2'b00,
        ModeGy  = 2'b01,
        ModeMag = 2'b10,
        ModeRsv = 2'b11
    } mode_e;

    // Two's complement negation, kept explicit so the kernel terms read as in the maths.
    function automatic term_t f_neg(input term_t a);
        return ~a + term_t'(1);
    endfunction

    // Handshake / stall
    logic w_advance;
    logic w_out_hs;

    // Window pixels zero-extended into the signed result width
    term_t w_pix [9];

    // Stage 1 inputs and registers
    term_t            w_tx [6];
    term_t            w_ty [6];
    term_t            r_s1_tx [6];
    term_t            r_s1_ty [6];
    logic             r_s1_valid;
    logic [1:0]       r_s1_mode;
    logic [TW-1:0]    r_s1_thresh;

    // Stage 2 inputs and registers
    term_t            w_gx;
    term_t            w_gy;
    term_t            r_s2_gx;
    term_t            r_s2_gy;
    logic             r_s2_valid;
    logic [1:0]       r_s2_mode;
    logic [TW-1:0]    r_s2_thresh;

    // Stage 3 inputs and registers
    logic [GW-1:0]    w_gx_abs;
    logic [GW-1:0]    w_gy_abs;
    logic [GW-1:0]    w_mag;
    logic [GW-1:0]    w_grad;
    logic             w_edge;
    logic [GW-1:0]    r_grad;
    logic             r_edge;
    logic             r_out_valid;

    logic [CNT_W-1:0] r_edge_count;

    assign w_advance = !(r_out_valid && !i_out_ready);
    assign w_out_hs  = r_out_valid && i_out_ready;

    assign w_pix[0] = $signed({4'b0000, i_p1});
    assign w_pix[1] = $signed({4'b0000, i_p2});
    assign w_pix[2] = $signed({4'b0000, i_p3});
    assign w_pix[3] = $signed({4'b0000, i_p4});
    assign w_pix[4] = $signed({4'b0000, i_p5});
    assign w_pix[5] = $signed({4'b0000, i_p6});
    assign w_pix[6] = $signed({4'b0000, i_p7});
    assign w_pix[7] = $signed({4'b0000, i_p8});
    assign w_pix[8] = $signed({4'b0000, i_p9});

    // Weighted kernel terms: the centre pixel carries zero weight in both kernels
    always_comb begin
        w_tx[0] = w_pix[0];
        w_tx[1] = f_neg(w_pix[2]);
        w_tx[2] = w_pix[3] <<< 1;
        w_tx[3] = f_neg(w_pix[5] <<< 1);
        w_tx[4] = w_pix[6];
        w_tx[5] = f_neg(w_pix[8]);

        w_ty[0] = w_pix[0];
        w_ty[1] = w_pix[1] <<< 1;
        w_ty[2] = w_pix[2];
        w_ty[3] = f_neg(w_pix[6]);
        w_ty[4] = f_neg(w_pix[7] <<< 1);
        w_ty[5] = f_neg(w_pix[8]);
    end

    // Stage 1: capture the terms plus the per-beat mode and threshold
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_s1_valid  <= 1'b0;
            r_s1_mode   <= 2'b00;
            r_s1_thresh <= '0;
            for (int i = 0; i < 6; i++) begin
                r_s1_tx[i] <= '0;
                r_s1_ty[i] <= '0;
            end
        end else if (w_advance) begin
            r_s1_valid  <= i_in_valid;
            r_s1_mode   <= i_mode;
            r_s1_thresh <= i_thresh;
            for (int i = 0; i < 6; i++) begin
                r_s1_tx[i] <= w_tx[i];
                r_s1_ty[i] <= w_ty[i];
            end
        end
    end

    // Kernel sums: GW bits hold +/-4*(2^PIX_W-1) without overflow
    always_comb begin
        w_gx = r_s1_tx[0] + r_s1_tx[1] + r_s1_tx[2] + r_s1_tx[3] + r_s1_tx[4] + r_s1_tx[5];
        w_gy = r_s1_ty[0] + r_s1_ty[1] + r_s1_ty[2] + r_s1_ty[3] + r_s1_ty[4] + r_s1_ty[5];
    end

    // Stage 2: capture Gx, Gy and carry mode/threshold alongside
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_s2_valid  <= 1'b0;
            r_s2_gx     <= '0;
            r_s2_gy     <= '0;
            r_s2_mode   <= 2'b00;
            r_s2_thresh <= '0;
        end else if (w_advance) begin
            r_s2_valid  <= r_s1_valid;
            r_s2_gx     <= w_gx;
            r_s2_gy     <= w_gy;
            r_s2_mode   <= r_s1_mode;
            r_s2_thresh <= r_s1_thresh;
        end
    end

    // Magnitude, result select and edge decision; |Gx|+|Gy| tops out at 8*(2^PIX_W-1)
    always_comb begin
        w_gx_abs = r_s2_gx[GW-1] ? f_neg(r_s2_gx) : r_s2_gx;
        w_gy_abs = r_s2_gy[GW-1] ? f_neg(r_s2_gy) : r_s2_gy;
        w_mag    = w_gx_abs + w_gy_abs;
        w_edge   = w_mag > {1'b0, r_s2_thresh};
        w_grad   = w_mag;
        case (mode_e'(r_s2_mode))
            ModeGx:  w_grad = r_s2_gx;
            ModeGy:  w_grad = r_s2_gy;
            ModeMag: w_grad = w_mag;
            ModeRsv: w_grad = w_mag;
            default: w_grad = w_mag;
        endcase
    end

    // Stage 3: registered result, held while downstream stalls
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_out_valid <= 1'b0;
            r_grad      <= '0;
            r_edge      <= 1'b0;
        end else if (w_advance) begin
            r_out_valid <= r_s2_valid;
            r_grad      <= w_grad;
            r_edge      <= w_edge;
        end
    end

    // Saturating count of delivered edge beats; clear has priority
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_edge_count <= '0;
        end else if (i_cnt_clr) begin
            r_edge_count <= '0;
        end else if (w_out_hs && r_edge && (r_edge_count != '1)) begin
            r_edge_count <= r_edge_count + 1'b1;
        end
    end

    assign o_in_ready   = w_advance;
    assign o_out_valid  = r_out_valid;
    assign o_grad       = r_grad;
    assign o_edge       = r_edge;
    assign o_edge_count = r_edge_count;

endmodule

// File: tb/tb_sobel_grad_pipe.sv
// Self-checking bench for sobel_grad_pipe (PIX_W=4). A second instance with a
// 3-bit counter shares all stimulus so counter saturation is reachable quickly.
module tb_sobel_grad_pipe;

    logic        clk = 1'b0;
    logic        i_rst;
    logic        i_in_valid;
    logic        o_in_ready;
    logic [3:0]  i_p1, i_p2, i_p3, i_p4, i_p5, i_p6, i_p7, i_p8, i_p9;
    logic [1:0]  i_mode;
    logic [6:0]  i_thresh;
    logic        i_cnt_clr;
    logic        o_out_valid;
    logic        i_out_ready;
    logic [7:0]  o_grad;
    logic        o_edge;
    logic [15:0] o_edge_count;

    logic        sat_in_ready;
    logic        sat_out_valid;
    logic [7:0]  sat_grad;
    logic        sat_edge;
    logic [2:0]  sat_count;

    int n_checks = 0;
    int n_errors = 0;

    typedef struct packed {
        logic [7:0] grad;
        logic       edge_b;
    } exp_t;

    exp_t exp_q[$];
    int   cnt_m = 0;
    int   sat_m = 0;
    int   n_deliv = 0;
    logic prev_stall = 1'b0;
    logic [7:0] prev_grad;
    logic prev_edge;

    always #5 clk = ~clk;

    sobel_grad_pipe #(.PIX_W(4), .CNT_W(16)) dut (
        .i_clk(clk), .i_rst(i_rst), .i_in_valid(i_in_valid), .o_in_ready(o_in_ready),
        .i_p1(i_p1), .i_p2(i_p2), .i_p3(i_p3), .i_p4(i_p4), .i_p5(i_p5),
        .i_p6(i_p6), .i_p7(i_p7), .i_p8(i_p8), .i_p9(i_p9),
        .i_mode(i_mode), .i_thresh(i_thresh), .i_cnt_clr(i_cnt_clr),
        .o_out_valid(o_out_valid), .i_out_ready(i_out_ready), .o_grad(o_grad),
        .o_edge(o_edge), .o_edge_count(o_edge_count)
    );

    sobel_grad_pipe #(.PIX_W(4), .CNT_W(3)) dut_sat (
        .i_clk(clk), .i_rst(i_rst), .i_in_valid(i_in_valid), .o_in_ready(sat_in_ready),
        .i_p1(i_p1), .i_p2(i_p2), .i_p3(i_p3), .i_p4(i_p4), .i_p5(i_p5),
        .i_p6(i_p6), .i_p7(i_p7), .i_p8(i_p8), .i_p9(i_p9),
        .i_mode(i_mode), .i_thresh(i_thresh), .i_cnt_clr(i_cnt_clr),
        .o_out_valid(sat_out_valid), .i_out_ready(i_out_ready), .o_grad(sat_grad),
        .o_edge(sat_edge), .o_edge_count(sat_count)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_checks++;
        if (obs !== exp_v) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp_v, $time);
        end
    endtask

    // Reference: Sobel sums in plain integer arithmetic, pix holds p1 in the top nibble
    function automatic void ref_model(input logic [35:0] pix, input logic [1:0] mode,
                                      input logic [6:0] th, output logic [7:0] g,
                                      output logic e);
        int p [9];
        int gx, gy, mag;
        for (int i = 0; i < 9; i++) p[i] = int'(pix[35-4*i -: 4]);
        gx  = p[0] - p[2] + 2*p[3] - 2*p[5] + p[6] - p[8];
        gy  = p[0] + 2*p[1] + p[2] - p[6] - 2*p[7] - p[8];
        mag = (gx < 0 ? -gx : gx) + (gy < 0 ? -gy : gy);
        case (mode)
            2'd0:    g = 8'(gx);
            2'd1:    g = 8'(gy);
            default: g = 8'(mag);
        endcase
        e = mag > int'(th);
    endfunction

    // Scoreboard: counters, stall stability, ordering of delivered results
    always @(negedge clk) begin
        exp_t e;
        logic hs;
        if (i_rst) begin
            exp_q.delete();
            cnt_m = 0;
            sat_m = 0;
            prev_stall = 1'b0;
        end else begin
            chk("edge_count", o_edge_count, cnt_m);
            chk("edge_count_sat", sat_count, sat_m);
            chk("in_ready", o_in_ready, !(o_out_valid && !i_out_ready));
            if (prev_stall) begin
                chk("stall_valid", o_out_valid, 1);
                chk("stall_grad", o_grad, prev_grad);
                chk("stall_edge", o_edge, prev_edge);
            end
            prev_stall = o_out_valid && !i_out_ready;
            prev_grad  = o_grad;
            prev_edge  = o_edge;
            hs = o_out_valid && i_out_ready;
            e  = '0;
            if (exp_q.size() == 0) begin
                chk("spurious_out", o_out_valid, 0);
            end else if (hs) begin
                e = exp_q.pop_front();
                n_deliv++;
                chk("sb_grad", o_grad, e.grad);
                chk("sb_edge", o_edge, e.edge_b);
            end
            if (i_cnt_clr) begin
                cnt_m = 0;
                sat_m = 0;
            end else if (hs && e.edge_b) begin
                if (cnt_m != 65535) cnt_m++;
                if (sat_m != 7) sat_m++;
            end
            if (i_in_valid && o_in_ready) begin
                ref_model({i_p1, i_p2, i_p3, i_p4, i_p5, i_p6, i_p7, i_p8, i_p9},
                          i_mode, i_thresh, e.grad, e.edge_b);
                exp_q.push_back(e);
            end
        end
    end

    // Present one beat (called just after a rising edge); returns just after its accepting edge
    task automatic drive_beat(input logic [35:0] pix, input logic [1:0] mode,
                              input logic [6:0] th);
        logic got = 1'b0;
        {i_p1, i_p2, i_p3, i_p4, i_p5, i_p6, i_p7, i_p8, i_p9} = pix;
        i_mode     = mode;
        i_thresh   = th;
        i_in_valid = 1'b1;
        for (int n = 0; n < 200; n++) begin
            @(negedge clk);
            if (o_in_ready) begin
                got = 1'b1;
                break;
            end
        end
        if (!got) chk("accept_timeout", got, 1);
        @(posedge clk);
        #1;
        i_in_valid = 1'b0;
    endtask

    // Single isolated beat: checks exact latency and the spec's expected result
    task automatic run_vec(input string tag, input logic [35:0] pix, input logic [1:0] mode,
                           input logic [6:0] th, input logic [7:0] eg, input logic ee);
        @(posedge clk);
        #1;
        i_out_ready = 1'b1;
        drive_beat(pix, mode, th);
        @(negedge clk);
        chk({tag, "_lat1"}, o_out_valid, 0);
        @(negedge clk);
        chk({tag, "_lat2"}, o_out_valid, 0);
        @(negedge clk);
        chk({tag, "_lat3"}, o_out_valid, 1);
        chk({tag, "_grad"}, o_grad, eg);
        chk({tag, "_edge"}, o_edge, ee);
    endtask

    task automatic drain();
        for (int n = 0; n < 300 && exp_q.size() != 0; n++) @(negedge clk);
        chk("drain", exp_q.size(), 0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic [35:0] rp;
        logic [7:0]  eg;
        logic        ee;
        logic        done;
        logic        got;
        int          d0;

        i_rst = 1'b1;
        i_in_valid = 1'b0;
        {i_p1, i_p2, i_p3, i_p4, i_p5, i_p6, i_p7, i_p8, i_p9} = '0;
        i_mode = 2'b00;
        i_thresh = '0;
        i_cnt_clr = 1'b0;
        i_out_ready = 1'b1;

        repeat (3) @(posedge clk);
        #1;
        chk("rst_out_valid", o_out_valid, 0);
        chk("rst_in_ready", o_in_ready, 1);
        chk("rst_grad", o_grad, 0);
        chk("rst_edge", o_edge, 0);
        chk("rst_count", o_edge_count, 0);
        @(posedge clk);
        #1;
        i_rst = 1'b0;

        // Directed vectors
        run_vec("flat",       36'h555_555_555, 2'b00, 7'd0,  8'h00, 1'b0);
        run_vec("lcol_gx",    36'hF00_F00_F00, 2'b00, 7'd50, 8'h3C, 1'b1);
        run_vec("lcol_mag",   36'hF00_F00_F00, 2'b10, 7'd50, 8'h3C, 1'b1);
        run_vec("rcol_gx",    36'h00F_00F_00F, 2'b00, 7'd0,  8'hC4, 1'b1);
        run_vec("top_gy",     36'hFFF_000_000, 2'b01, 7'd0,  8'h3C, 1'b1);
        run_vec("bot_gy",     36'h000_000_FFF, 2'b01, 7'd0,  8'hC4, 1'b1);
        run_vec("corner_89",  36'hFF0_F00_000, 2'b10, 7'd89, 8'h5A, 1'b1);
        run_vec("corner_90",  36'hFF0_F00_000, 2'b10, 7'd90, 8'h5A, 1'b0);
        run_vec("corner_rsv", 36'hFF0_F00_000, 2'b11, 7'd89, 8'h5A, 1'b1);
        run_vec("corner_gx",  36'hFF0_F00_000, 2'b00, 7'd90, 8'h2D, 1'b0);

        // Stall: A held for 4 cycles, then A..D delivered in order
        drain();
        @(posedge clk);
        #1;
        i_out_ready = 1'b0;
        d0 = n_deliv;
        ref_model(36'hF00_F00_F00, 2'b00, 7'd50, eg, ee);
        fork
            begin
                drive_beat(36'hF00_F00_F00, 2'b00, 7'd50);
                drive_beat(36'h00F_00F_00F, 2'b00, 7'd10);
                drive_beat(36'hFF0_F00_000, 2'b10, 7'd89);
                drive_beat(36'h123_456_789, 2'b00, 7'd3);
            end
            begin
                got = 1'b0;
                for (int n = 0; n < 20; n++) begin
                    @(negedge clk);
                    if (o_out_valid) begin
                        got = 1'b1;
                        break;
                    end
                end
                chk("stall_reach", got, 1);
                for (int s = 0; s < 4; s++) begin
                    if (s > 0) @(negedge clk);
                    chk("stall_hold_valid", o_out_valid, 1);
                    chk("stall_hold_grad", o_grad, eg);
                    chk("stall_in_ready", o_in_ready, 0);
                end
                @(posedge clk);
                #1;
                i_out_ready = 1'b1;
            end
        join
        drain();
        chk("stall_delivered", n_deliv - d0, 4);

        // Randomized traffic with backpressure and occasional counter clears
        done = 1'b0;
        fork
            begin
                for (int k = 0; k < 300; k++) begin
                    repeat ($urandom_range(0, 2)) begin
                        @(posedge clk);
                        #1;
                    end
                    for (int i = 0; i < 9; i++) rp[4*i +: 4] = 4'($urandom_range(0, 15));
                    drive_beat(rp, 2'($urandom_range(0, 3)), 7'($urandom_range(0, 127)));
                end
                done = 1'b1;
            end
            begin
                while (!done) begin
                    @(posedge clk);
                    #1;
                    i_out_ready = ($urandom_range(0, 3) != 0);
                    i_cnt_clr   = ($urandom_range(0, 40) == 0);
                end
                i_out_ready = 1'b1;
                i_cnt_clr   = 1'b0;
            end
        join
        drain();

        // Saturation of the narrow counter, exact count on the wide one
        @(posedge clk);
        #1;
        i_cnt_clr = 1'b1;
        @(posedge clk);
        #1;
        i_cnt_clr = 1'b0;
        for (int k = 0; k < 9; k++) run_vec("sat_beat", 36'hF00_F00_F00, 2'b00, 7'd0, 8'h3C, 1'b1);
        @(posedge clk);
        #1;
        chk("count_nine", o_edge_count, 9);
        chk("count_saturated", sat_count, 7);

        // Clear concurrent with an edge handshake
        drive_beat(36'hF00_F00_F00, 2'b00, 7'd0);
        @(posedge clk);
        @(posedge clk);
        #1;
        i_cnt_clr = 1'b1;
        @(negedge clk);
        chk("clr_hs_valid", o_out_valid, 1);
        @(posedge clk);
        #1;
        i_cnt_clr = 1'b0;
        chk("clr_wins", o_edge_count, 0);
        chk("clr_wins_sat", sat_count, 0);
        run_vec("pre_rst", 36'hF00_F00_F00, 2'b00, 7'd0, 8'h3C, 1'b1);

        // Reset pulsed with three beats in flight
        @(posedge clk);
        #1;
        drive_beat(36'hF00_F00_F00, 2'b00, 7'd0);
        drive_beat(36'h00F_00F_00F, 2'b00, 7'd0);
        drive_beat(36'hFFF_000_000, 2'b01, 7'd0);
        #2;
        i_rst = 1'b1;
        #1;
        chk("arst_out_valid", o_out_valid, 0);
        chk("arst_in_ready", o_in_ready, 1);
        chk("arst_grad", o_grad, 0);
        chk("arst_edge", o_edge, 0);
        chk("arst_count", o_edge_count, 0);
        @(posedge clk);
        @(posedge clk);
        #1;
        i_rst = 1'b0;
        for (int n = 0; n < 8; n++) begin
            @(negedge clk);
            chk("post_rst_quiet", o_out_valid, 0);
        end
        run_vec("after_rst", 36'h00F_00F_00F, 2'b00, 7'd59, 8'hC4, 1'b1);
        drain();

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
